// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, 1-cycle-latency SRAM reads, DEPTH-entry fetch buffer.
// Optional macro IF_FETCH_CNT_EN adds the fetch_cnt delivered-instruction counter.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 8,
  parameter int          DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              PCSrc,
  input  logic [31:0]       branch_target,
  output logic              isram_rd,
  output logic [ADDR_W-1:0] isram_addr,
  input  logic [31:0]       isram_dout,
  output logic [31:0]       instn,
  output logic              instn_valid,
  output logic [31:0]       instn_pc,
  output logic [31:0]       pc_plus4
`ifdef IF_FETCH_CNT_EN
  ,
  output logic [31:0]       fetch_cnt
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);
  localparam logic [PW-1:0] LAST_P  = PW'(DEPTH - 1);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } entry_t;

  entry_t        buf_q [DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   fl_pc_q, fl_pc_d;
  logic          fl_q, fl_d;
  logic [CW:0]   occ;
  logic          pop, push, issue;
  entry_t        head;

  function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
    if (p == LAST_P) return '0;
    return p + 1'b1;
  endfunction

  assign occ         = {1'b0, cnt_q} + (CW+1)'(fl_q);
  assign instn_valid = (cnt_q != '0) & ~PCSrc;
  assign pop         = instn_valid & ~stall;
  // In-flight data landing during a redirect is dropped, never buffered.
  assign push        = fl_q & ~PCSrc;
  // rst_n term keeps the read enable low while reset is held.
  assign issue       = rst_n & ~PCSrc & ((occ < DEPTH_C) | ((occ == DEPTH_C) & pop));

  assign isram_rd   = issue;
  assign isram_addr = pc_q[ADDR_W+1:2];

  assign head     = buf_q[rd_q];
  assign instn    = instn_valid ? head.ins : 32'h0;
  assign instn_pc = instn_valid ? head.pc  : 32'h0;
  assign pc_plus4 = instn_pc + 32'd4;

  always_comb begin
    pc_d    = pc_q;
    fl_d    = 1'b0;
    fl_pc_d = fl_pc_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    if (PCSrc) begin
      pc_d  = {branch_target[31:2], 2'b00};
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (issue) begin
        pc_d    = pc_q + 32'd4;
        fl_d    = 1'b1;
        fl_pc_d = pc_q;
      end
      if (push) wr_d = inc_ptr(wr_q);
      if (pop)  rd_d = inc_ptr(rd_q);
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      fl_q    <= 1'b0;
      fl_pc_q <= 32'h0;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      fl_q    <= fl_d;
      fl_pc_q <= fl_pc_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only observed once counted valid.
  always_ff @(posedge clk) begin
    if (push) buf_q[wr_q] <= '{pc: fl_pc_q, ins: isram_dout};
  end

`ifdef IF_FETCH_CNT_EN
  logic [31:0] fcnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   fcnt_q <= 32'h0;
    else if (pop) fcnt_q <= fcnt_q + 32'd1;
  end

  assign fetch_cnt = fcnt_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed stimulus, expected fetch stream queued for a negedge monitor.
module tb_if_stage;
  logic        clk = 1'b0;
  logic        rst_n, stall, PCSrc;
  logic [31:0] branch_target;
  logic        isram_rd;
  logic [7:0]  isram_addr;
  logic [31:0] isram_dout;
  logic [31:0] instn, instn_pc, pc_plus4;
  logic        instn_valid;
`ifdef IF_FETCH_CNT_EN
  logic [31:0] fetch_cnt;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  exp_t exp_q[$];
  int   vecs = 0;
  int   errs = 0;
  int   dlv  = 0;
  int   dlv_base = 0;

  if_stage #(.RESET_PC(32'h0), .ADDR_W(8), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .PCSrc(PCSrc),
    .branch_target(branch_target), .isram_rd(isram_rd), .isram_addr(isram_addr),
    .isram_dout(isram_dout), .instn(instn), .instn_valid(instn_valid),
    .instn_pc(instn_pc), .pc_plus4(pc_plus4)
`ifdef IF_FETCH_CNT_EN
    , .fetch_cnt(fetch_cnt)
`endif
  );

  always #5 clk = ~clk;

  // SRAM model: word at address a is 32'h1000_0000 + a, 1-cycle latency.
  always @(posedge clk) begin
    if (isram_rd) isram_dout <= 32'h1000_0000 + {24'h0, isram_addr};
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic push_stream(input logic [31:0] base, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.pc  = base + 32'(4 * i);
      e.ins = 32'h1000_0000 + {24'h0, e.pc[9:2]};
      exp_q.push_back(e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every delivered instruction must be the next queued one.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (PCSrc) begin
        chk("redir_valid", {31'h0, instn_valid}, 32'h0);
        chk("redir_rd", {31'h0, isram_rd}, 32'h0);
      end
      if (!instn_valid) chk("nop_instn", instn, 32'h0);
      if (instn_valid && !stall && !PCSrc) begin
        dlv++;
        if (exp_q.size() == 0) begin
          chk("unexpected_instn", instn_pc, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("stream_instn", instn, e.ins);
          chk("stream_pc", instn_pc, e.pc);
          chk("stream_pc4", pc_plus4, e.pc + 32'd4);
        end
      end
    end
  end

  initial begin
    int d0;
    rst_n = 1'b0; stall = 1'b0; PCSrc = 1'b0; branch_target = 32'h0;
    #2;
    chk("rst_valid", {31'h0, instn_valid}, 32'h0);
    chk("rst_rd", {31'h0, isram_rd}, 32'h0);
    chk("rst_pc4", pc_plus4, 32'h4);
    step(); step();
    push_stream(32'h0, 64);
    rst_n = 1'b1;
    step();
    chk("lat_valid_n1", {31'h0, instn_valid}, 32'h0);
    step();
    // First valid: stall right away for 5 cycles.
    stall = 1'b1;
    #1;
    chk("first_valid", {31'h0, instn_valid}, 32'h1);
    chk("first_instn", instn, 32'h1000_0000);
    chk("first_pc", instn_pc, 32'h0);
    for (int k = 0; k < 5; k++) begin
      chk("stall_hold", instn, exp_q[0].ins);
      chk("stall_hold_pc", instn_pc, exp_q[0].pc);
      chk("stall_no_rd", {31'h0, isram_rd}, 32'h0);
      step();
    end
    stall = 1'b0;
    d0 = dlv;
    for (int k = 0; k < 8; k++) step();
    chk("throughput", 32'(dlv - d0), 32'd8);

    // Fill buffer, then redirect together with stall.
    stall = 1'b1;
    step(); step();
    PCSrc = 1'b1; branch_target = 32'h0000_0043;
    exp_q.delete();
    push_stream(32'h40, 64);
    #1;
    chk("redir_valid0", {31'h0, instn_valid}, 32'h0);
    step();
    PCSrc = 1'b0; stall = 1'b0;
    #1;
    chk("redir_addr", {24'h0, isram_addr}, 32'h10);
    chk("redir_issue", {31'h0, isram_rd}, 32'h1);
    chk("redir_flushed", {31'h0, instn_valid}, 32'h0);
    step();
    chk("redir_lat", {31'h0, instn_valid}, 32'h0);
    step();
    chk("tgt_instn", instn, 32'h1000_0010);
    chk("tgt_pc", instn_pc, 32'h40);
    for (int k = 0; k < 5; k++) step();

    // Back-to-back redirects: only the last target streams.
    PCSrc = 1'b1; branch_target = 32'h20;
    exp_q.delete();
    step();
    branch_target = 32'h80;
    exp_q.delete();
    push_stream(32'h80, 64);
    step();
    PCSrc = 1'b0;
    #1;
    chk("b2b_addr", {24'h0, isram_addr}, 32'h20);
    for (int k = 0; k < 7; k++) step();

    // Reset mid-stream with a full buffer.
    stall = 1'b1;
    step(); step();
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", {31'h0, instn_valid}, 32'h0);
    chk("mrst_instn", instn, 32'h0);
    chk("mrst_pc", instn_pc, 32'h0);
    chk("mrst_pc4", pc_plus4, 32'h4);
    chk("mrst_rd", {31'h0, isram_rd}, 32'h0);
    chk("mrst_addr", {24'h0, isram_addr}, 32'h0);
    stall = 1'b0;
    exp_q.delete();
    push_stream(32'h0, 64);
    step();
    dlv_base = dlv;
    rst_n = 1'b1;
    step(); step();
    chk("rst2_instn", instn, 32'h1000_0000);
    chk("rst2_pc", instn_pc, 32'h0);

    // 10 deliveries, then a redirect that flushes 2 buffered entries.
    for (int k = 0; k < 10; k++) step();
    stall = 1'b1;
    step();
    chk("cnt_base", 32'(dlv - dlv_base), 32'd10);
    PCSrc = 1'b1; branch_target = 32'h100;
    exp_q.delete();
    push_stream(32'h100, 64);
    step();
    PCSrc = 1'b0;
`ifdef IF_FETCH_CNT_EN
    chk("fetch_cnt", fetch_cnt, 32'd10);
`endif
    stall = 1'b0;
    for (int k = 0; k < 6; k++) step();
`ifdef IF_FETCH_CNT_EN
    chk("fetch_cnt_end", fetch_cnt, 32'(dlv - dlv_base));
`endif
    chk("final_dlv", 32'(dlv - dlv_base), 32'd14);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
